// File: rtl/scrambler_key_scheduler_if.sv
// rtl/scrambler_key_scheduler_if.sv - config memory port and host byte-read port of the key scheduler
interface scrambler_key_scheduler_if #(
    parameter int ADDR_W = 8
) ();
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_q;
    logic              host_rd_req;
    logic [ADDR_W-1:0] host_addr;
    logic              host_rd_ack;
    logic              host_rd_valid;
    logic [7:0]        host_rd_data;

    modport master (
        output host_rd_req, host_addr, mem_q,
        input  mem_addr, host_rd_ack, host_rd_valid, host_rd_data
    );

    modport slave (
        input  host_rd_req, host_addr, mem_q,
        output mem_addr, host_rd_ack, host_rd_valid, host_rd_data
    );
endinterface

// File: rtl/scrambler_key_scheduler.sv
// rtl/scrambler_key_scheduler.sv - loads MODE/seed from config memory, commits at vsync, arbitrates host reads
// Optional checksum verification of offset 1 is enabled by defining SCRAMBLER_KEY_CHECKSUM_EN.
module scrambler_key_scheduler #(
    parameter int ADDR_W       = 8,
    parameter int READ_LATENCY = 2,
    parameter int NUM_BANKS    = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    scrambler_key_scheduler_if.slave     bus_if,
    input  logic                         rekey_req_i,
    input  logic [$clog2(NUM_BANKS)-1:0] rekey_bank_i,
    input  logic                         vsync_i,
    output logic                         busy_o,
    output logic                         key_valid_o,
    output logic                         key_err_o,
    output logic                         mode_o,
    output logic [255:0]                 seed_o,
    output logic                         reset_n_scrambler_o
);
    localparam int BANK_W = $clog2(NUM_BANKS);
`ifdef SCRAMBLER_KEY_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif
    localparam logic [5:0] NUM_READS = CK_EN ? 6'd34 : 6'd33;

    typedef enum logic [2:0] {S_BOOT, S_IDLE, S_LOAD, S_WAIT_VS, S_COMMIT} state_t;

    state_t              state_q;
    logic [BANK_W-1:0]   bank_q;
    logic [5:0]          iss_cnt_q;
    logic [5:0]          cap_cnt_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                host_ack_q;
    logic [READ_LATENCY:0] tag_vld_q;
    logic [READ_LATENCY:0] tag_host_q;
    logic [5:0]          tag_idx_q [READ_LATENCY+1];
    logic                shadow_mode_q, shadow_mode_d;
    logic [255:0]        shadow_seed_q, shadow_seed_d;
    logic [7:0]          shadow_ck_q, shadow_ck_d;
    logic                mode_q;
    logic [255:0]        seed_q;
    logic                key_valid_q, key_err_q, rst_scr_q, busy_q;

    logic                loader_on, host_go, cap_go, cap_last, ck_ok;
    logic [5:0]          iss_idx, iss_off, cap_idx;
    logic [ADDR_W-1:0]   iss_addr;
    logic [7:0]          seed_xor;

    // Tag index: 0 = MODE byte, 1 = checksum byte, 2..33 = seed bytes 0..31.
    assign loader_on = ((state_q == S_BOOT) || (state_q == S_LOAD)) && (iss_cnt_q != NUM_READS);
    assign host_go   = bus_if.host_rd_req && !host_ack_q && !loader_on;
    assign iss_idx   = CK_EN ? iss_cnt_q : ((iss_cnt_q == 6'd0) ? 6'd0 : iss_cnt_q + 6'd1);
    assign iss_off   = (iss_idx < 6'd2) ? iss_idx : iss_idx + 6'd30;
    assign iss_addr  = (ADDR_W'(bank_q) << 6) + ADDR_W'(iss_off);

    // Stage 0 pairs with the registered mem_addr; the last stage lines up with mem_q.
    assign cap_go   = tag_vld_q[READ_LATENCY] && !tag_host_q[READ_LATENCY];
    assign cap_idx  = tag_idx_q[READ_LATENCY];
    assign cap_last = cap_go && (cap_cnt_q == NUM_READS - 6'd1);

    always_comb begin
        shadow_mode_d = shadow_mode_q;
        shadow_ck_d   = shadow_ck_q;
        shadow_seed_d = shadow_seed_q;
        if (cap_go) begin
            if (cap_idx == 6'd0) begin
                shadow_mode_d = bus_if.mem_q[0];
            end else if (cap_idx == 6'd1) begin
                shadow_ck_d = bus_if.mem_q;
            end else begin
                shadow_seed_d[int'(6'd33 - cap_idx) * 8 +: 8] = bus_if.mem_q;
            end
        end
    end

    always_comb begin
        seed_xor = 8'd0;
        for (int i = 0; i < 32; i++) begin
            seed_xor = seed_xor ^ shadow_seed_d[8*i +: 8];
        end
    end

    assign ck_ok = !CK_EN || (seed_xor == shadow_ck_d);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_BOOT;
            bank_q        <= '0;
            iss_cnt_q     <= 6'd0;
            cap_cnt_q     <= 6'd0;
            mem_addr_q    <= '0;
            host_ack_q    <= 1'b0;
            tag_vld_q     <= '0;
            tag_host_q    <= '0;
            for (int i = 0; i <= READ_LATENCY; i++) begin
                tag_idx_q[i] <= 6'd0;
            end
            shadow_mode_q <= 1'b0;
            shadow_seed_q <= '0;
            shadow_ck_q   <= 8'd0;
            mode_q        <= 1'b0;
            seed_q        <= '0;
            key_valid_q   <= 1'b0;
            key_err_q     <= 1'b0;
            rst_scr_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            shadow_mode_q <= shadow_mode_d;
            shadow_seed_q <= shadow_seed_d;
            shadow_ck_q   <= shadow_ck_d;
            host_ack_q    <= host_go;
            tag_vld_q[0]  <= loader_on || host_go;
            tag_host_q[0] <= host_go;
            tag_idx_q[0]  <= iss_idx;
            for (int i = 1; i <= READ_LATENCY; i++) begin
                tag_vld_q[i]  <= tag_vld_q[i-1];
                tag_host_q[i] <= tag_host_q[i-1];
                tag_idx_q[i]  <= tag_idx_q[i-1];
            end
            if (loader_on) begin
                mem_addr_q <= iss_addr;
                iss_cnt_q  <= iss_cnt_q + 6'd1;
            end else if (host_go) begin
                mem_addr_q <= bus_if.host_addr;
            end
            if (cap_go) begin
                cap_cnt_q <= cap_cnt_q + 6'd1;
            end
            busy_q <= (state_q != S_IDLE);

            case (state_q)
                S_BOOT: begin
                    // Boot commits straight away; the scrambler leaves reset on this edge.
                    if (cap_last) begin
                        if (ck_ok) begin
                            state_q     <= S_COMMIT;
                            mode_q      <= shadow_mode_d;
                            seed_q      <= shadow_seed_d;
                            key_valid_q <= 1'b1;
                            key_err_q   <= 1'b0;
                            rst_scr_q   <= 1'b1;
                        end else begin
                            state_q   <= S_IDLE;
                            key_err_q <= 1'b1;
                            busy_q    <= 1'b0;
                        end
                    end
                end
                S_IDLE: begin
                    if (rekey_req_i) begin
                        state_q   <= S_LOAD;
                        bank_q    <= rekey_bank_i;
                        iss_cnt_q <= 6'd0;
                        cap_cnt_q <= 6'd0;
                        busy_q    <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (cap_last) begin
                        state_q <= S_WAIT_VS;
                    end
                end
                S_WAIT_VS: begin
                    if (vsync_i) begin
                        if (ck_ok) begin
                            state_q     <= S_COMMIT;
                            mode_q      <= shadow_mode_d;
                            seed_q      <= shadow_seed_d;
                            key_valid_q <= 1'b1;
                            key_err_q   <= 1'b0;
                            rst_scr_q   <= 1'b0;
                        end else begin
                            state_q   <= S_IDLE;
                            key_err_q <= 1'b1;
                            busy_q    <= 1'b0;
                        end
                    end
                end
                S_COMMIT: begin
                    state_q   <= S_IDLE;
                    rst_scr_q <= 1'b1;
                    busy_q    <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus_if.mem_addr      = mem_addr_q;
    assign bus_if.host_rd_ack   = host_ack_q;
    assign bus_if.host_rd_valid = tag_vld_q[READ_LATENCY] && tag_host_q[READ_LATENCY];
    assign bus_if.host_rd_data  = bus_if.host_rd_valid ? bus_if.mem_q : 8'd0;
    assign busy_o               = busy_q;
    assign key_valid_o          = key_valid_q;
    assign key_err_o            = key_err_q;
    assign mode_o               = mode_q;
    assign seed_o               = seed_q;
    assign reset_n_scrambler_o  = rst_scr_q;
endmodule
